// File: rtl/rxd_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : rxd_pkg                                                    |
// | Description : Shared types and constants for the UART receive path:      |
// |               receiver FSM state encoding, oversampling constants and    |
// |               the baud divisor helper.                                   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package rxd_pkg;

  typedef enum logic [2:0] {
    WAIT_IDLE = 3'd0,
    IDLE      = 3'd1,
    START     = 3'd2,
    DATA      = 3'd3,
    PARITY    = 3'd4,
    STOP      = 3'd5
  } rxd_state_e;

  localparam int OVERSAMPLE = 16;
  localparam int MID_SAMPLE = 7;
  localparam int DATA_BITS  = 8;

  // Clocks per oversample tick, truncated, never below one.
  function automatic int calc_div(input int clk_freq, input int baud);
    int d;
    d = clk_freq / (baud * OVERSAMPLE);
    return (d < 1) ? 1 : d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rxd_sync_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : rxd_sync_fifo                                              |
// | Description : Single-clock first-word-fall-through byte FIFO with        |
// |               depth 2**FIFO_AW. A push while full is accepted only when  |
// |               a pop happens in the same cycle.                           |
// | Ports       : clk, rst          - clock, synchronous active-high reset   |
// |               i_push/i_push_data - write request and byte                |
// |               i_pop             - pop head (ignored when empty)          |
// |               o_rd_data         - head byte, 0 when empty                |
// |               o_empty/o_full/o_count - occupancy status                  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module rxd_sync_fifo
  import rxd_pkg::*;
#(
  parameter int FIFO_AW = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_push,
  input  logic [7:0]         i_push_data,
  input  logic               i_pop,
  output logic [7:0]         o_rd_data,
  output logic               o_empty,
  output logic               o_full,
  output logic [FIFO_AW:0]   o_count
);

  localparam int               DEPTH   = 2 ** FIFO_AW;
  localparam logic [FIFO_AW:0] DEPTH_C = (FIFO_AW + 1)'(DEPTH);

  logic [7:0]         mem_q [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]   count_q,  count_d;
  logic               w_pop_en;
  logic               w_push_en;

  assign o_empty = (count_q == '0);
  assign o_full  = (count_q == DEPTH_C);
  assign o_count = count_q;

  // Gating with empty keeps the head output at zero after reset even
  // though the storage array itself is not reset.
  assign o_rd_data = o_empty ? 8'h00 : mem_q[rd_ptr_q];

  always_comb begin
    w_pop_en  = i_pop && !o_empty;
    w_push_en = i_push && (!o_full || w_pop_en);
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    if (w_push_en) wr_ptr_d = wr_ptr_q + 1'b1;
    if (w_pop_en)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (w_push_en && !w_pop_en)      count_d = count_q + 1'b1;
    else if (w_pop_en && !w_push_en) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_en) mem_q[wr_ptr_q] <= i_push_data;
  end

endmodule
`default_nettype wire

// File: rtl/rxd_wrapper.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : rxd_wrapper                                                |
// | Description : UART receive path. Synchronises SDI, oversamples at 16x,   |
// |               deserialises 8N1 frames (8E1 when RXD_PARITY_EN is         |
// |               defined) LSB first and queues good bytes in a FWFT FIFO.   |
// | Ports       : Clock, Reset  - clock, synchronous active-high reset       |
// |               SDI           - async serial input, idle high              |
// |               rdEn          - pop head byte (ignored when empty)         |
// |               clearErrors   - clears the sticky error flags              |
// |               rdData/rdValid/fifoFull - FIFO read side and status        |
// |               frameError/overflow/parityError - sticky error flags       |
// | Macro       : RXD_PARITY_EN - enables even-parity checking               |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module rxd_wrapper #(
  parameter int CLK_FREQ = 100000000,
  parameter int BAUD     = 115200,
  parameter int FIFO_AW  = 5
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       SDI,
  input  logic       rdEn,
  input  logic       clearErrors,
  output logic [7:0] rdData,
  output logic       rdValid,
  output logic       fifoFull,
  output logic       frameError,
  output logic       overflow,
  output logic       parityError
);
  import rxd_pkg::*;

  localparam int               DIV       = calc_div(CLK_FREQ, BAUD);
  localparam int               TW        = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [TW-1:0]    TICK_LAST = TW'(DIV - 1);
  localparam logic [3:0]       SCNT_MID  = 4'(MID_SAMPLE);
  localparam logic [3:0]       SCNT_LAST = 4'(OVERSAMPLE - 1);
  localparam logic [2:0]       BIT_LAST  = 3'(DATA_BITS - 1);
  localparam logic [FIFO_AW:0] DEPTH_C   = (FIFO_AW + 1)'(2 ** FIFO_AW);

  // ---------------- synchroniser ----------------
  logic [1:0] sync_q, sync_d;
  logic       sdi_s;

  always_comb sync_d = {sync_q[0], SDI};
  assign sdi_s = sync_q[1];

  // ---------------- state and datapath registers ----------------
  rxd_state_e    state_q, state_d;
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic [3:0]    scnt_q, scnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          push_q, push_d;
  logic          frame_err_q, frame_err_d;
  logic          overflow_q, overflow_d;
  logic          tick;
  logic          mid;
  logic          last;
  logic          frame_set;
  logic          overflow_set;

  logic          fifo_empty;
  logic          fifo_full;
  logic [FIFO_AW:0] fifo_count;

`ifdef RXD_PARITY_EN
  logic          par_bad_q, par_bad_d;
  logic          parity_err_q, parity_err_d;
  logic          parity_set;
`endif

  // ---------------- tick generator ----------------
  // Counter is held at zero while waiting for a start edge so the first
  // tick of a frame lands a whole DIV period after the edge was seen.
  always_comb begin
    tick_cnt_d = tick_cnt_q;
    tick       = 1'b0;
    if (state_q == IDLE || state_q == WAIT_IDLE) begin
      tick_cnt_d = '0;
    end else if (tick_cnt_q == TICK_LAST) begin
      tick_cnt_d = '0;
      tick       = 1'b1;
    end else begin
      tick_cnt_d = tick_cnt_q + 1'b1;
    end
  end

  assign mid  = tick && (scnt_q == SCNT_MID);
  assign last = tick && (scnt_q == SCNT_LAST);

  // ---------------- FSM: state register ----------------
  always_ff @(posedge Clock) begin
    if (Reset) state_q <= WAIT_IDLE;
    else       state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      WAIT_IDLE: if (sdi_s) state_d = IDLE;
      IDLE:      if (!sdi_s) state_d = START;
      START: begin
        if (mid && sdi_s) state_d = IDLE;   // start bit gone at midpoint: glitch
        else if (last)    state_d = DATA;
      end
      DATA: begin
        if (last && bit_idx_q == BIT_LAST) begin
`ifdef RXD_PARITY_EN
          state_d = PARITY;
`else
          state_d = STOP;
`endif
        end
      end
      PARITY: if (last) state_d = STOP;
      // Leave at the stop midpoint so a back-to-back start edge is caught.
      STOP:   if (mid) state_d = sdi_s ? IDLE : WAIT_IDLE;
      default: state_d = WAIT_IDLE;
    endcase
  end

  // ---------------- FSM: outputs / datapath ----------------
  always_comb begin
    scnt_d    = scnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    push_d    = 1'b0;
    frame_set = 1'b0;
`ifdef RXD_PARITY_EN
    par_bad_d  = par_bad_q;
    parity_set = 1'b0;
`endif
    case (state_q)
      START: begin
        if (tick) scnt_d = scnt_q + 4'd1;
        bit_idx_d = '0;
`ifdef RXD_PARITY_EN
        par_bad_d = 1'b0;
`endif
      end
      DATA: begin
        if (tick) scnt_d = scnt_q + 4'd1;
        if (mid)  shift_d = {sdi_s, shift_q[7:1]};
        if (last) bit_idx_d = bit_idx_q + 3'd1;
      end
      PARITY: begin
        if (tick) scnt_d = scnt_q + 4'd1;
`ifdef RXD_PARITY_EN
        if (mid) begin
          par_bad_d  = ^{shift_q, sdi_s};
          parity_set = ^{shift_q, sdi_s};
        end
`endif
      end
      STOP: begin
        if (tick) scnt_d = scnt_q + 4'd1;
        if (mid) begin
          if (sdi_s) begin
`ifdef RXD_PARITY_EN
            push_d = !par_bad_q;
`else
            push_d = 1'b1;
`endif
          end else begin
            frame_set = 1'b1;
          end
        end
      end
      default: scnt_d = '0;
    endcase
  end

  // ---------------- sticky error flags ----------------
  // A pop in the same cycle frees a slot, so only a push into a full FIFO
  // without a concurrent pop loses the byte.
  assign overflow_set = push_q && fifo_full && !(rdEn && !fifo_empty);

  always_comb begin
    frame_err_d = frame_set    ? 1'b1 : (clearErrors ? 1'b0 : frame_err_q);
    overflow_d  = overflow_set ? 1'b1 : (clearErrors ? 1'b0 : overflow_q);
`ifdef RXD_PARITY_EN
    parity_err_d = parity_set  ? 1'b1 : (clearErrors ? 1'b0 : parity_err_q);
`endif
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      sync_q      <= 2'b11;
      tick_cnt_q  <= '0;
      scnt_q      <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      push_q      <= 1'b0;
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
`ifdef RXD_PARITY_EN
      par_bad_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      sync_q      <= sync_d;
      tick_cnt_q  <= tick_cnt_d;
      scnt_q      <= scnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      push_q      <= push_d;
      frame_err_q <= frame_err_d;
      overflow_q  <= overflow_d;
`ifdef RXD_PARITY_EN
      par_bad_q    <= par_bad_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  // ---------------- receive FIFO ----------------
  // shift_q is stable until the next frame's first data midpoint, so it can
  // feed the FIFO directly in the cycle after the stop sample.
  rxd_sync_fifo #(
    .FIFO_AW (FIFO_AW)
  ) u_fifo (
    .clk         (Clock),
    .rst         (Reset),
    .i_push      (push_q),
    .i_push_data (shift_q),
    .i_pop       (rdEn),
    .o_rd_data   (rdData),
    .o_empty     (fifo_empty),
    .o_full      (fifo_full),
    .o_count     (fifo_count)
  );

  assign rdValid    = !fifo_empty;
  assign fifoFull   = (fifo_count == DEPTH_C);
  assign frameError = frame_err_q;
  assign overflow   = overflow_q;
`ifdef RXD_PARITY_EN
  assign parityError = parity_err_q;
`else
  assign parityError = 1'b0;
`endif

endmodule
`default_nettype wire
